// File: rtl/axis_width_downsizer.sv
// Serializes wide AXI-Stream words into narrow beats, LSB-first, with a per-word beat count.
// A new word is loaded on the same edge that retires the last beat of the previous one.
module axis_width_downsizer #(
    parameter int IN_WIDTH = 512,
    parameter int OUT_WIDTH = 8,
    localparam int RATIO = IN_WIDTH / OUT_WIDTH,
    localparam int CNT_WIDTH = $clog2(RATIO) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [IN_WIDTH-1:0]  s_axis_tdata,
    input  logic [CNT_WIDTH-1:0] s_axis_tcount,
    input  logic                 s_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [OUT_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tlast
);

    localparam logic [CNT_WIDTH-1:0] RATIO_CNT = CNT_WIDTH'(RATIO);
    localparam logic [CNT_WIDTH-1:0] ONE_CNT = CNT_WIDTH'(1);

    generate
        if ((IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_ratio
            $error("IN_WIDTH must be an integer multiple of OUT_WIDTH");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state, state_next;
    logic [IN_WIDTH-1:0]  shift, shift_next;
    logic [CNT_WIDTH-1:0] rem, rem_next;
    logic [CNT_WIDTH-1:0] count_clamped;
    logic                 last, last_next;
    logic                 last_beat;
    logic                 accept;
    logic                 beat_done;

    // Handshakes: a transfer happens on any edge where valid and ready are both high.
    assign last_beat     = (state == SEND) && (rem == ONE_CNT);
    assign s_axis_tready = reset_n && ((state == IDLE) || (last_beat && m_axis_tready));
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign beat_done     = m_axis_tvalid && m_axis_tready;
    assign count_clamped = (s_axis_tcount > RATIO_CNT) ? RATIO_CNT : s_axis_tcount;

    assign m_axis_tvalid = (state == SEND);
    assign m_axis_tdata  = (state == SEND) ? shift[OUT_WIDTH-1:0] : '0;
    assign m_axis_tlast  = last_beat && last;

    always_comb begin
        state_next = state;
        shift_next = shift;
        rem_next   = rem;
        last_next  = last;
        if (accept) begin
            // Also covers the overlap case: the final beat retires while the next word loads.
            shift_next = s_axis_tdata;
            rem_next   = count_clamped;
            last_next  = s_axis_tlast;
            state_next = (count_clamped != '0) ? SEND : IDLE;
        end else if (beat_done) begin
            shift_next = shift >> OUT_WIDTH;
            rem_next   = rem - ONE_CNT;
            if (rem == ONE_CNT) begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            shift <= '0;
            rem   <= '0;
            last  <= 1'b0;
        end else begin
            state <= state_next;
            shift <= shift_next;
            rem   <= rem_next;
            last  <= last_next;
        end
    end

    rem_bound: assert property (@(posedge clk) disable iff (!reset_n) rem <= RATIO_CNT);

    no_accept_mid_word: assert property (@(posedge clk) disable iff (!reset_n)
        ((state == SEND) && (rem > ONE_CNT)) |-> !s_axis_tready);

endmodule

// File: tb/tb_axis_width_downsizer.sv
// Bench for axis_width_downsizer: scenario tasks drive words, a monitor checks the beat stream
// against an expected queue, and each task checks its own timing/handshake properties.
module tb_axis_width_downsizer;

  localparam int IN_WIDTH = 512;
  localparam int OUT_WIDTH = 8;
  localparam int RATIO = 64;
  localparam int CNT_WIDTH = 7;

  logic                 clk;
  logic                 reset_n;
  logic                 s_tvalid;
  logic                 s_tready;
  logic [IN_WIDTH-1:0]  s_tdata;
  logic [CNT_WIDTH-1:0] s_tcount;
  logic                 s_tlast;
  logic                 m_tvalid;
  logic                 m_tready;
  logic [OUT_WIDTH-1:0] m_tdata;
  logic                 m_tlast;

  int checks = 0;
  int errors = 0;
  int beats_seen = 0;
  int lasts_seen = 0;
  logic mon_en = 1'b0;
  logic rand_mode = 1'b0;
  logic [OUT_WIDTH:0] exp_q[$];

  axis_width_downsizer dut (
    .clk(clk),
    .reset_n(reset_n),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tdata(s_tdata),
    .s_axis_tcount(s_tcount),
    .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata),
    .m_axis_tlast(m_tlast)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [IN_WIDTH-1:0] make_bytes(input logic [7:0] base);
    logic [IN_WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < RATIO; k++) r[k*OUT_WIDTH +: OUT_WIDTH] = base + 8'(k);
    return r;
  endfunction

  function automatic logic [IN_WIDTH-1:0] rand_word();
    logic [IN_WIDTH-1:0] r;
    for (int j = 0; j < IN_WIDTH / 32; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  // scoreboard: pops one expected {last,data} per output handshake, checks stall stability
  task automatic monitor_loop();
    logic prev_stall;
    logic [OUT_WIDTH-1:0] prev_data;
    logic prev_last;
    logic [OUT_WIDTH:0] exp;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last) begin
            errors++;
            $display("FAIL stall_hold: got valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                     m_tvalid, m_tdata, m_tlast, prev_data, prev_last);
          end
        end
        if (m_tvalid && m_tready) begin
          beats_seen++;
          if (m_tlast) lasts_seen++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got data=%h last=%b, want no beat", m_tdata, m_tlast);
          end else begin
            exp = exp_q.pop_front();
            if ({m_tlast, m_tdata} !== exp) begin
              errors++;
              $display("FAIL beat_data: got last=%b data=%h, want last=%b data=%h",
                       m_tlast, m_tdata, exp[OUT_WIDTH], exp[OUT_WIDTH-1:0]);
            end
          end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data = m_tdata;
        prev_last = m_tlast;
      end
    end
  endtask

  task automatic ready_loop();
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) m_tready = ($urandom_range(0, 1) == 1);
    end
  endtask

  // driver: pushes expected beats, holds the word until accepted, returns 1 ns after the accept edge
  task automatic send_word(input logic [IN_WIDTH-1:0] data, input int count, input logic last,
                           output logic overlap);
    int n;
    int waited;
    n = (count > RATIO) ? RATIO : count;
    waited = 0;
    for (int k = 0; k < n; k++) exp_q.push_back({last && (k == n - 1), data[k*OUT_WIDTH +: OUT_WIDTH]});
    s_tvalid = 1'b1;
    s_tdata = data;
    s_tcount = CNT_WIDTH'(count);
    s_tlast = last;
    @(negedge clk);
    while (!s_tready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: got s_tready=%b after %0d cycles, want 1", s_tready, waited);
    end
    overlap = m_tvalid && m_tready && m_tlast;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || m_tvalid) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (exp_q.size() != 0 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d beats pending, m_tvalid=%b, want 0 and 0", exp_q.size(), m_tvalid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    s_tvalid = 1'b0;
    s_tdata = '0;
    s_tcount = '0;
    s_tlast = 1'b0;
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready: got %b want 0", s_tready); end
    checks++;
    if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tlast !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h last=%b want 0 00 0", m_tvalid, m_tdata, m_tlast);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got s_tready=%b m_tvalid=%b want 1 0", s_tready, m_tvalid);
    end
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  task automatic test_single_word();
    logic ov;
    int b0, l0;
    m_tready = 1'b1;
    b0 = beats_seen;
    l0 = lasts_seen;
    send_word(make_bytes(8'h00), 64, 1'b1, ov);
    for (int k = 0; k < RATIO; k++) begin
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b1 || s_tready !== (k == RATIO - 1)) begin
        errors++;
        $display("FAIL single_beat%0d: got m_tvalid=%b s_tready=%b want 1 %b", k, m_tvalid, s_tready, k == RATIO - 1);
      end
    end
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0) begin errors++; $display("FAIL single_end_valid: got %b want 0", m_tvalid); end
    @(posedge clk);
    #1;
    checks++;
    if (beats_seen - b0 != 64 || lasts_seen - l0 != 1) begin
      errors++;
      $display("FAIL single_counts: got beats=%0d lasts=%0d want 64 1", beats_seen - b0, lasts_seen - l0);
    end
  endtask

  task automatic test_back_to_back();
    logic ov;
    m_tready = 1'b1;
    fork
      begin
        send_word(make_bytes(8'h00), 64, 1'b1, ov);
        send_word(make_bytes(8'h40), 64, 1'b0, ov);
        checks++;
        if (ov !== 1'b1) begin errors++; $display("FAIL b2b_overlap: got %b want 1", ov); end
      end
      begin
        int c;
        int gaps;
        c = 0;
        gaps = 0;
        @(negedge clk);
        while (!m_tvalid && c < 20) begin
          @(negedge clk);
          c++;
        end
        for (int i = 0; i < 2 * RATIO; i++) begin
          if (!m_tvalid) gaps++;
          @(negedge clk);
        end
        checks++;
        if (gaps != 0 || m_tvalid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_gaps: got gaps=%0d trailing_valid=%b want 0 0", gaps, m_tvalid);
        end
      end
    join
    wait_drain();
  endtask

  task automatic test_partial_empty();
    logic ov;
    logic [IN_WIDTH-1:0] d;
    int b0, l0;
    time t0;
    m_tready = 1'b1;
    d = make_bytes(8'h00);
    d[31:0] = 32'hDDCC_BBAA;
    b0 = beats_seen;
    l0 = lasts_seen;
    send_word(d, 3, 1'b1, ov);
    wait_drain();
    checks++;
    if (beats_seen - b0 != 3 || lasts_seen - l0 != 1) begin
      errors++;
      $display("FAIL partial_counts: got beats=%0d lasts=%0d want 3 1", beats_seen - b0, lasts_seen - l0);
    end
    b0 = beats_seen;
    l0 = lasts_seen;
    t0 = $time;
    send_word(make_bytes(8'h10), 0, 1'b1, ov);
    checks++;
    if ($time - t0 != 10) begin errors++; $display("FAIL empty_accept_time: got %0t want 10", $time - t0); end
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL empty_after: got s_tready=%b m_tvalid=%b want 1 0", s_tready, m_tvalid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (beats_seen != b0 || lasts_seen != l0) begin
      errors++;
      $display("FAIL empty_counts: got beats=%0d lasts=%0d want 0 0", beats_seen - b0, lasts_seen - l0);
    end
    @(posedge clk);
    #1;
    b0 = beats_seen;
    l0 = lasts_seen;
    send_word(make_bytes(8'h20), 70, 1'b1, ov);
    wait_drain();
    checks++;
    if (beats_seen - b0 != 64 || lasts_seen - l0 != 1) begin
      errors++;
      $display("FAIL clamp_counts: got beats=%0d lasts=%0d want 64 1", beats_seen - b0, lasts_seen - l0);
    end
  endtask

  task automatic test_random();
    logic ov;
    logic lst;
    int cnt, l0, exp_lasts;
    l0 = lasts_seen;
    exp_lasts = 0;
    rand_mode = 1'b1;
    for (int w = 0; w < 20; w++) begin
      cnt = $urandom_range(0, 70);
      lst = ($urandom_range(0, 1) == 1);
      if (lst && cnt > 0) exp_lasts++;
      send_word(rand_word(), cnt, lst, ov);
    end
    wait_drain();
    rand_mode = 1'b0;
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    checks++;
    if (lasts_seen - l0 != exp_lasts) begin
      errors++;
      $display("FAIL random_lasts: got %0d want %0d", lasts_seen - l0, exp_lasts);
    end
  endtask

  task automatic test_reset_mid();
    logic ov;
    m_tready = 1'b1;
    send_word(make_bytes(8'h40), 64, 1'b1, ov);
    repeat (10) @(posedge clk);
    #1;
    mon_en = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b0) begin errors++; $display("FAIL mid_reset_s_tready: got %b want 0", s_tready); end
    @(posedge clk);
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_next: got m_tvalid=%b s_tready=%b want 0 0", m_tvalid, s_tready);
    end
    exp_q.delete();
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b1 || m_tvalid !== 1'b0 || m_tdata !== '0) begin
      errors++;
      $display("FAIL mid_reset_release: got s_tready=%b m_tvalid=%b data=%h want 1 0 00", s_tready, m_tvalid, m_tdata);
    end
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    send_word(make_bytes(8'h80), 64, 1'b1, ov);
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 8'h80) begin
      errors++;
      $display("FAIL mid_reset_first_beat: got valid=%b data=%h want 1 80", m_tvalid, m_tdata);
    end
    wait_drain();
  endtask

  initial begin
    fork
      monitor_loop();
      ready_loop();
    join_none
    test_reset();
    test_single_word();
    test_back_to_back();
    test_partial_empty();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
